// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Number of 4-bit slices needed for a given operand width.
  function automatic int unsigned num_slices(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_slice_4.sv
// Combinational 4-bit carry-lookahead slice; every carry is a flat
// generate/propagate sum of products, so there is no ripple path.
module cla_slice_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ {c[3:1], cin};
  assign cout = c[4];

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor: one 4-bit CLA slice per clock,
// LSB slice first, with a start/done handshake.
// Optional feature: define DIGIT_SERIAL_ADDSUB_OVERFLOW_EN to build the signed
// overflow flag; otherwise overflow is tied low.
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned NS   = num_slices(WIDTH);
  localparam int unsigned IdxW = (NS > 1) ? $clog2(NS) : 1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              c_out_q, c_out_d;
`ifdef DIGIT_SERIAL_ADDSUB_OVERFLOW_EN
  logic              ovf_q, ovf_d;
`endif

  int unsigned       base;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic              sl_cout;
  logic              last;

  // Select the current slice; subtraction inverts in2 here, the +1 enters as carry-in.
  always_comb begin
    base = 32'(idx_q) * SLICE_W;
    sl_a = a_q[base +: SLICE_W];
    sl_b = b_q[base +: SLICE_W] ^ {SLICE_W{sub_q}};
    last = (idx_q == IdxW'(NS - 1));
  end

  cla_slice_4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .s    (sl_s),
    .cout (sl_cout)
  );

  // Next-state logic: FSM, operand capture and in-place result update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
`ifdef DIGIT_SERIAL_ADDSUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          sub_d   = op_sub;
          idx_d   = '0;
          carry_d = op_sub;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[base +: SLICE_W] = sl_s;
        c_out_d = sl_cout;
        carry_d = sl_cout;
        if (last) begin
`ifdef DIGIT_SERIAL_ADDSUB_OVERFLOW_EN
          ovf_d = (sl_a[SLICE_W-1] == sl_b[SLICE_W-1]) && (sl_s[SLICE_W-1] != sl_a[SLICE_W-1]);
`endif
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous abort to reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
`ifdef DIGIT_SERIAL_ADDSUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
`ifdef DIGIT_SERIAL_ADDSUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign c_out  = c_out_q;
`ifdef DIGIT_SERIAL_ADDSUB_OVERFLOW_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub: a driver pushes expected results
// from an arithmetic model, a monitor pops and compares on every done.
module tb_digit_serial_addsub;

  localparam int unsigned W  = 16;
  localparam int unsigned NS = W / 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          op_sub = 1'b0;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic          busy, done, c_out, overflow;
  logic [W-1:0]  result;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sub   (op_sub),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    int           t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   n_pushed = 0;
  int   cyc      = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for carry/borrow, signed for overflow.
  function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint ua, ub, sa, sb, full, sfull;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    full  = sub ? (ua - ub) : (ua + ub);
    sfull = sub ? (sa - sb) : (sa + sb);
    e.res = W'(full);
    e.c   = sub ? (ua >= ub) : (full >= (longint'(1) << W));
`ifdef DIGIT_SERIAL_ADDSUB_OVERFLOW_EN
    e.ov  = (sfull > ((longint'(1) << (W - 1)) - 1)) || (sfull < -(longint'(1) << (W - 1)));
`else
    e.ov  = 1'b0;
`endif
    e.t0  = 0;
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      check("done_pulse_width", W'(prev_done), W'(0));
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done actual=result %h required=no done", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("c_out", W'(c_out), W'(e.c));
        check("overflow", W'(overflow), W'(e.ov));
        check("latency", W'(cyc - e.t0), W'(NS + 1));
      end
    end
    prev_done <= done;
  end

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout actual=busy 1 required=busy 0");
    end
  endtask

  // Drive one request for a single cycle; returns in the first RUN cycle.
  task automatic issue(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    exp_t e;
    wait_idle();
    in1 = a;
    in2 = b;
    op_sub = sub;
    start = 1'b1;
    if (push) begin
      e = model(sub, a, b);
      e.t0 = cyc;
      exp_q.push_back(e);
      n_pushed++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int k;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, W'(0));
    check("rst_c_out", W'(c_out), W'(0));
    check("rst_overflow", W'(overflow), W'(0));
    rst_n = 1'b1;

    // Directed cases
    issue(1'b0, 16'h1234, 16'h0F0F, 1'b1);
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b1);
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b1);
    issue(1'b1, 16'h0005, 16'h0007, 1'b1);
    issue(1'b1, 16'h0007, 16'h0005, 1'b1);
    issue(1'b1, 16'h8000, 16'h0001, 1'b1);
    issue(1'b1, 16'h1234, 16'h1234, 1'b1);

    // Starts during RUN and during DONE must be ignored
    issue(1'b0, 16'h1111, 16'h2222, 1'b1);
    @(negedge clk);
    in1 = 16'hFFFF; in2 = 16'hFFFF; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Asynchronous abort in the second RUN cycle
    issue(1'b0, 16'hABCD, 16'h1111, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_result", result, W'(0));
    check("abort_c_out", W'(c_out), W'(0));
    check("abort_overflow", W'(overflow), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 16'h0001, 16'h0001, 1'b1);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b1);
    end

    // Drain
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("outstanding", W'(exp_q.size()), W'(0));
    check("done_count", W'(n_done), W'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/digit_serial_addsub.md
# digit_serial_addsub

- Multi-cycle WIDTH-bit adder/subtractor that processes operands one 4-bit carry-lookahead slice per clock, least-significant slice first.
- Subtraction is computed as in1 + ~in2 + 1 on the same slice datapath.
- Sits behind the 4-bit CLA datapath as the sequential, wide-operand front end.
- A start/done handshake lets a controller issue wide arithmetic without instantiating a full-width adder.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = add, 1 = subtract; sampled with start.
- in1  input  WIDTH  first operand; sampled with start.
- in2  input  WIDTH  second operand; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, result valid.
- result  output  WIDTH  sum or difference, held until next accepted start.
- c_out  output  1  carry out of MSB; for subtract, 1 = no borrow (in1 >= in2 unsigned).
- overflow  output  1  signed two's-complement overflow.

## Operation
- NS = WIDTH/4 slices. States are IDLE, RUN and DONE.
- IDLE: when start = 1, latch in1, in2 and op_sub; set the slice index to 0 and the carry register to op_sub; go to RUN. When start = 0, stay in IDLE.
- RUN, slice k:
  - b_k = in2[4k+3:4k], XOR-ed with op_sub replicated.
  - Compute in1[4k+3:4k] + b_k + carry.
  - Write the sum into result[4k+3:4k] and store the slice carry-out.
  - After slice NS-1, go to DONE.
- DONE: lasts one cycle. done = 1, then return to IDLE.
- result and c_out update in place during RUN. Their values are valid only from the done cycle until the next accepted start.
- Sign-bit rule: overflow = (in1[MSB] == b[MSB]) && (result[MSB] != in1[MSB]), where b is the possibly inverted in2. It is computed on the last slice.
- start while busy = 1 is ignored. The request is not queued and no state changes.
- start in the same cycle as done (DONE state) is ignored. It is accepted the following cycle in IDLE.
- Reset values: state IDLE, busy 0, done 0, result 0, c_out 0, overflow 0, and all internal registers 0.
- rst_n low mid-operation aborts immediately (asynchronously) to reset values. No done is issued for the aborted request.

## Timing
- Start accepted at rising edge T: busy = 1 after T. RUN occupies cycles T+1 … T+NS, and done = 1 in cycle T+NS+1.
- Latency from accepted start to done is NS+1 cycles (5 for WIDTH = 16).
- Throughput is one operation per NS+2 cycles.
- Slice carry is registered between cycles. The combinational path is one 4-bit CLA plus the in2 inversion.

## Configuration
- DIGIT_SERIAL_ADDSUB_OVERFLOW_EN defined: the overflow logic is built, and overflow is registered on the last RUN cycle.
- Not defined: overflow is tied to 0 and the sign-bit compare logic is absent. The port remains present.

## Structure
- Shared package addsub_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - SLICE_W = 4;
  - a function computing NS from WIDTH.
- One sub-module, cla_slice_4: combinational 4-bit carry-lookahead slice with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout. It uses generate/propagate terms with no ripple.
- Top level holds the FSM, operand registers, slice index counter, carry register and result register.

## Test plan
Tests use WIDTH = 16 unless noted.
1. Add 0x1234 + 0x0F0F -> result 0x2143, c_out 0, overflow 0; done exactly 5 cycles after the start edge, pulse width 1.
2. Add 0xFFFF + 0x0001 -> result 0x0000, c_out 1, overflow 0. Add 0x7FFF + 0x0001 -> 0x8000, c_out 0, overflow 1.
3. Subtract 0x0005 - 0x0007 -> 0xFFFE, c_out 0 (borrow), overflow 0. Subtract 0x0007 - 0x0005 -> 0x0002, c_out 1.
4. Subtract 0x8000 - 0x0001 -> 0x7FFF, c_out 1, overflow 1 with the macro defined and 0 without.
5. Start an add of 0x1111 + 0x2222, then pulse start with 0xFFFF + 0xFFFF during RUN and during DONE -> only 0x3333 is produced, and exactly one done.
6. Assert rst_n low in the second RUN cycle -> busy, done, result, c_out and overflow are 0 immediately. After release, a new add of 0x0001 + 0x0001 yields 0x0002 with 5-cycle latency.
